parser_ingress_arbiter: RTL and testbench
=========================================

// Module: parser_ingress_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter sharing the sequence parser's single 32-bit ingress among NUM_SRC
//  upstream packet sources. Grants one source at a time and forwards its words unmodified until the
//  word flagged last is accepted, then re-arbitrates. Sits directly in front of the parser receive port;
//  reports grant id, packet count and an overlength-packet error.
// PARAMETERS
//  NUM_SRC        4    number of upstream sources (2..8)
//  DATA_W         32   word width; must match parser ingress
//  MAX_PKT_WORDS  12   words per packet incl. 2 header words; more without last raises overlength_err
// PORTS
//  clk             in   1                clock
//  reset           in   1                synchronous, active-high reset
//  src_data        in   NUM_SRC*DATA_W   source i word at [i*DATA_W +: DATA_W]
//  src_val         in   NUM_SRC          source i word valid
//  src_last        in   NUM_SRC          source i word is last of packet
//  src_ready       out  NUM_SRC          accept to source i; at most one bit high
//  dataIn          out  DATA_W           word to parser
//  dataIn_val      out  1                word valid to parser
//  dataIN_last     out  1                last word to parser
//  dataIn_ready    in   1                parser accept
//  grant_id        out  $clog2(NUM_SRC)  currently/last granted source
//  grant_active    out  1                a packet is in flight
//  pkt_count       out  16               packets fully forwarded, wraps 0xFFFF->0
//  overlength_err  out  1                one-cycle pulse on overlength detection
// BEHAVIOUR
//  - Reset: state IDLE, src_ready=0, dataIn_val=0, dataIN_last=0, dataIn=0, grant_active=0,
//    grant_id=0, pkt_count=0, overlength_err=0, rr_ptr=NUM_SRC-1 (source 0 wins first). Reset mid-packet
//    abandons packet; no flush; upstream must restart it.
//  - States: IDLE, FORWARD.
//  - IDLE: if any src_val, pick first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC; register
//    grant_id, grant_active=1, word_cnt=0, go FORWARD next cycle. No src_ready/dataIn_val in IDLE
//    (1-cycle arbitration bubble per packet). No request: stay IDLE, grant_id holds.
//  - FORWARD: combinational passthrough, zero latency:
//    dataIn=src_data[grant_id], dataIn_val=src_val[grant_id], dataIN_last=src_last[grant_id],
//    src_ready[grant_id]=dataIn_ready, other src_ready bits 0. Transfer = dataIn_val & dataIn_ready.
//  - Each transfer: word_cnt+1 (saturating 8-bit). Transfer with last: rr_ptr<=grant_id,
//    pkt_count+1, grant_active<=0, go IDLE. Next grant earliest 2 cycles after last transfer.
//  - Overlength: transfer with last=0 when word_cnt==MAX_PKT_WORDS-1 -> overlength_err pulses 1 cycle
//    after; grant kept (packet never split) until last arrives. One pulse per packet.
//  - Source deasserting src_val mid-packet: grant held, dataIn_val follows src_val; no timeout.
//  - Other sources' val/last/data ignored while FORWARD; their src_ready stays 0.
//  - Parser back-pressure (dataIn_ready=0, e.g. output pending): words stall in source; nothing buffered.
//  - Simultaneous requests: strictly round-robin; a source that just finished is lowest priority next.
//  - Single requester: regranted every packet, 1 bubble cycle between packets.
//  - grant_id invalid for data when grant_active=0; dataIn driven 0 in IDLE.
// TESTING
//  1 reset; src0 sends 3-word pkt (0x000C0005,0x00000001,0xAABBCCDD last), dataIn_ready=1 -> 3 words
//    out on consecutive cycles after 1 bubble, src_ready=4'b0001, pkt_count=1, grant_id=0.
//  2 all 4 sources request continuously with 3-word pkts -> grant order 0,1,2,3,0,...; every packet
//    contiguous; pkt_count=8 after 8 packets.
//  3 src2 mid-packet, dataIn_ready low 5 cycles -> dataIn/dataIn_val stable, src_ready[2]=0, no loss,
//    src1 requesting is not granted until src2 last accepted.
//  4 src1 sends 14 words before last (MAX=12) -> overlength_err single pulse after 12th word, all
//    14 words forwarded, then re-arbitrate.
//  5 reset asserted on 2nd word of src3 packet -> next cycle all outputs at reset values; after release
//    src0 and src3 both requesting -> src0 granted.
//  6 pkt_count preset via 65535 packets (or force) -> next packet wraps to 0.

Source files
------------

// File: rtl/parser_ingress_arbiter.sv
// Packet-atomic round-robin arbiter feeding the sequence parser's single ingress port.
// One source owns the port from grant until its last word is accepted; data passes through with zero latency.
module parser_ingress_arbiter #(
    parameter  int NUM_SRC       = 4,
    parameter  int DATA_W        = 32,
    parameter  int MAX_PKT_WORDS = 12,
    localparam int ID_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_val,
    input  logic [NUM_SRC-1:0]          src_last,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic [DATA_W-1:0]           dataIn,
    output logic                        dataIn_val,
    output logic                        dataIN_last,
    input  logic                        dataIn_ready,
    output logic [ID_W-1:0]             grant_id,
    output logic                        grant_active,
    output logic [15:0]                 pkt_count,
    output logic                        overlength_err
);

    typedef enum logic {
        IDLE,
        FORWARD
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              grant_active_q, grant_active_d;
    logic [7:0]        word_cnt_q, word_cnt_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
    logic              overlength_err_q, overlength_err_d;

    logic [DATA_W-1:0] src_word [NUM_SRC];
    logic [ID_W-1:0]   rr_pick;
    logic              rr_found;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_word[g] = src_data[g*DATA_W +: DATA_W];
    end

    // Search starts just after the last packet's owner, so it becomes lowest priority.
    always_comb begin
        int              idx_int;
        logic [ID_W-1:0] idx;
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        rr_pick  = '0;
        rr_found = 1'b0;
        idx_int  = 0;
        idx      = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx_int = (int'(rr_ptr_q) + i) % NUM_SRC;
            idx     = ID_W'(idx_int);
            if (!rr_found && src_val[idx]) begin
                rr_pick  = idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_id_d       = grant_id_q;
        rr_ptr_d         = rr_ptr_q;
        grant_active_d   = grant_active_q;
        word_cnt_d       = word_cnt_q;
        pkt_count_d      = pkt_count_q;
        overlength_err_d = 1'b0;
        src_ready        = '0;
        dataIn           = '0;
        dataIn_val       = 1'b0;
        dataIN_last      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_id_d     = rr_pick;
                    grant_active_d = 1'b1;
                    word_cnt_d     = '0;
                    state_d        = FORWARD;
                end
            end
            FORWARD: begin
                dataIn                = src_word[grant_id_q];
                dataIn_val            = src_val[grant_id_q];
                dataIN_last           = src_last[grant_id_q];
                src_ready[grant_id_q] = dataIn_ready;
                if (dataIn_val && dataIn_ready) begin
                    if (word_cnt_q != 8'hFF) begin
                        word_cnt_d = word_cnt_q + 8'd1;
                    end
                    if (dataIN_last) begin
                        rr_ptr_d       = grant_id_q;
                        pkt_count_d    = pkt_count_q + 16'd1;
                        grant_active_d = 1'b0;
                        state_d        = IDLE;
                    end else if (word_cnt_q == 8'(MAX_PKT_WORDS - 1)) begin
                        // Grant is kept; the packet is never split, only flagged once.
                        overlength_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it is only tested inside the clocked block; no async sensitivity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            grant_id_q       <= '0;
            rr_ptr_q         <= ID_W'(NUM_SRC - 1);
            grant_active_q   <= 1'b0;
            word_cnt_q       <= '0;
            pkt_count_q      <= '0;
            overlength_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q          <= state_d;
            grant_id_q       <= grant_id_d;
            rr_ptr_q         <= rr_ptr_d;
            grant_active_q   <= grant_active_d;
            word_cnt_q       <= word_cnt_d;
            pkt_count_q      <= pkt_count_d;
            overlength_err_q <= overlength_err_d;
        end
    end

    assign grant_id       = grant_id_q;
    assign grant_active   = grant_active_q;
    assign pkt_count      = pkt_count_q;
    assign overlength_err = overlength_err_q;

endmodule

// File: tb/tb_parser_ingress_arbiter.sv
// Scoreboard bench for parser_ingress_arbiter: stimulus pushes expected words in grant order,
// a negedge monitor pops and compares every accepted word.
module tb_parser_ingress_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_val;
    logic [NUM_SRC-1:0]        src_last;
    logic [NUM_SRC-1:0]        src_ready;
    logic [DATA_W-1:0]         dataIn;
    logic                      dataIn_val;
    logic                      dataIN_last;
    logic                      dataIn_ready = 1'b1;
    logic [1:0]                grant_id;
    logic                      grant_active;
    logic [15:0]               pkt_count;
    logic                      overlength_err;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
        logic        last;
    } exp_t;

    word_t        src_q [NUM_SRC][$];
    exp_t         exp_q [$];
    int           checks = 0;
    int           errors = 0;
    int           ovl_pulses = 0;
    int           pkt_words = 0;
    logic [3:0]   fire;

    parser_ingress_arbiter #(
        .NUM_SRC      (NUM_SRC),
        .DATA_W       (DATA_W),
        .MAX_PKT_WORDS(12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_data      (src_data),
        .src_val       (src_val),
        .src_last      (src_last),
        .src_ready     (src_ready),
        .dataIn        (dataIn),
        .dataIn_val    (dataIn_val),
        .dataIN_last   (dataIN_last),
        .dataIn_ready  (dataIn_ready),
        .grant_id      (grant_id),
        .grant_active  (grant_active),
        .pkt_count     (pkt_count),
        .overlength_err(overlength_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() != 0) begin
                src_val[i]                   = 1'b1;
                src_last[i]                  = src_q[i][0].last;
                src_data[i*DATA_W +: DATA_W] = src_q[i][0].data;
            end else begin
                src_val[i]                   = 1'b0;
                src_last[i]                  = 1'b0;
                src_data[i*DATA_W +: DATA_W] = 32'hDEAD_0000 | i;
            end
        end
    endtask

    task automatic push_word(input int src, input logic [31:0] data, input logic last);
        word_t w;
        exp_t  e;
        w.data = data;
        w.last = last;
        e.src  = 2'(src);
        e.data = data;
        e.last = last;
        src_q[src].push_back(w);
        exp_q.push_back(e);
    endtask

    task automatic push_pkt(input int src, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            push_word(src, base + 32'(k), (k == n - 1));
        end
        drive_srcs();
    endtask

    // Caller is aligned at posedge+2; reset is applied on the next edge.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        exp_q.delete();
        pkt_words = 0;
        drive_srcs();
        @(negedge clk);
        check("rst_src_ready",      32'(src_ready),      32'h0);
        check("rst_dataIn_val",     32'(dataIn_val),     32'h0);
        check("rst_dataIN_last",    32'(dataIN_last),    32'h0);
        check("rst_dataIn",         dataIn,              32'h0);
        check("rst_grant_active",   32'(grant_active),   32'h0);
        check("rst_grant_id",       32'(grant_id),       32'h0);
        check("rst_pkt_count",      32'(pkt_count),      32'h0);
        check("rst_overlength_err", 32'(overlength_err), 32'h0);
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        @(negedge clk);
        @(posedge clk); #2;
    endtask

    task automatic wait_grant(input logic [1:0] id, input int max_cycles);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(grant_active && grant_id == id) && c < max_cycles);
        check("wait_grant", 32'(grant_active && grant_id == id), 32'h1);
    endtask

    // Source model: a word leaves its queue once the handshake seen at negedge completes on the edge.
    initial begin
        drive_srcs();
        forever begin
            @(negedge clk);
            fire = src_val & src_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            end
            drive_srcs();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (overlength_err) begin
            ovl_pulses++;
            check("ovl_word_idx", 32'(pkt_words), 32'd12);
        end
        if (dataIn_val && dataIn_ready && !reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", dataIn);
            end else begin
                e = exp_q.pop_front();
                check("sb_data",      dataIn,                e.data);
                check("sb_last",      32'(dataIN_last),      32'(e.last));
                check("sb_grant_id",  32'(grant_id),         32'(e.src));
                check("sb_src_ready", 32'(src_ready),        32'(4'b0001 << e.src));
                pkt_words++;
                if (e.last) pkt_words = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single 3-word packet from source 0: one bubble, then three back-to-back words.
        push_word(0, 32'h000C_0005, 1'b0);
        push_word(0, 32'h0000_0001, 1'b0);
        push_word(0, 32'hAABB_CCDD, 1'b1);
        drive_srcs();
        @(negedge clk);
        check("t1_bubble_val",   32'(dataIn_val), 32'h0);
        check("t1_bubble_ready", 32'(src_ready),  32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_val",       32'(dataIn_val), 32'h1);
            check("t1_src_ready", 32'(src_ready),  32'h1);
        end
        @(negedge clk);
        check("t1_pkt_count",    32'(pkt_count),    32'd1);
        check("t1_grant_active", 32'(grant_active), 32'h0);
        check("t1_grant_id",     32'(grant_id),     32'h0);
        @(posedge clk); #2;

        // All four sources request two packets each: grants go 0,1,2,3,0,1,2,3.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                push_pkt(s, 3, 32'h0100_0000 * (s + 1) + 32'h10 * p);
            end
        end
        drain("t2", 200);
        check("t2_pkt_count", 32'(pkt_count), 32'd8);

        // Back-pressure mid-packet on source 2 while source 1 waits.
        push_pkt(2, 4, 32'h2000_0000);
        wait_grant(2'd2, 10);
        @(posedge clk); #2;
        dataIn_ready = 1'b0;
        push_pkt(1, 3, 32'h1000_0000);
        repeat (5) begin
            @(negedge clk);
            check("t3_stall_data",  dataIn,            32'h2000_0001);
            check("t3_stall_val",   32'(dataIn_val),   32'h1);
            check("t3_stall_ready", 32'(src_ready),    32'h0);
            check("t3_stall_grant", 32'(grant_id),     32'h2);
        end
        @(posedge clk); #2;
        dataIn_ready = 1'b1;
        drain("t3", 100);
        check("t3_pkt_count", 32'(pkt_count), 32'd10);

        // Exactly-max packet (src3) raises nothing; 14-word packet (src1) pulses once.
        ovl_pulses = 0;
        push_pkt(3, 12, 32'h3000_0000);
        push_pkt(1, 14, 32'h1100_0000);
        drain("t4", 200);
        check("t4_ovl_pulses", 32'(ovl_pulses), 32'd1);
        check("t4_pkt_count",  32'(pkt_count),  32'd12);

        // Reset on the second word of a source-3 packet, then 0 and 3 compete.
        push_pkt(3, 3, 32'h3300_0000);
        wait_grant(2'd3, 10);
        @(posedge clk); #2;
        do_reset();
        push_pkt(0, 2, 32'h0500_0000);
        push_pkt(3, 2, 32'h3500_0000);
        wait_grant(2'd0, 10);
        drain("t5", 100);
        check("t5_pkt_count", 32'(pkt_count), 32'd2);

        // Counter preset to its maximum; the next packet wraps it.
        @(negedge clk);
        force dut.pkt_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_count_q;
        check("t6_preset", 32'(pkt_count), 32'h0000_FFFF);
        @(posedge clk); #2;
        push_pkt(2, 2, 32'h2600_0000);
        drain("t6", 100);
        check("t6_wrap", 32'(pkt_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
